// File: rtl/ppu_pkg.sv
// Shared PPU definitions: operation codes and posit bit-level helpers.
// Helpers work on a PMAX-bit word and take the posit width n as argument.
package ppu_pkg;

    localparam int OP_SIZE = 2;
    localparam int PMAX    = 64;

    typedef logic [PMAX-1:0] pword_t;

    localparam logic [OP_SIZE-1:0] ADD = 2'd0;
    localparam logic [OP_SIZE-1:0] SUB = 2'd1;
    localparam logic [OP_SIZE-1:0] MUL = 2'd2;
    localparam logic [OP_SIZE-1:0] DIV = 2'd3;

    // n-bit mask in the low bits of a PMAX word
    function automatic pword_t pmask(int unsigned n);
        return {PMAX{1'b1}} >> (PMAX - n);
    endfunction

    function automatic pword_t c2(pword_t v, int unsigned n);
        return (~v + pword_t'(1)) & pmask(n);
    endfunction

    // NaR maps to 2^(n-1), the largest magnitude
    function automatic pword_t abs_posit(pword_t v, int unsigned n);
        return v[n-1] ? c2(v, n) : (v & pmask(n));
    endfunction

    function automatic logic is_zero(pword_t v, int unsigned n);
        return (v & pmask(n)) == '0;
    endfunction

    function automatic logic is_nar(pword_t v, int unsigned n);
        return (v & pmask(n)) == (pword_t'(1) << (n - 1));
    endfunction

endpackage

// File: rtl/ppu_pipe_reg.sv
// Valid/ready register slice with a generic payload.
// Ports: in_valid/in_ready/in_data upstream, out_valid/out_ready/out_data down.
module ppu_pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         v;
    logic [W-1:0] d;

    assign in_ready  = !v || out_ready;
    assign out_valid = v;
    assign out_data  = d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v <= 1'b0;
            d <= '0;
        end else if (in_ready) begin
            v <= in_valid;
            if (in_valid) begin
                d <= in_data;
            end
        end
    end

endmodule

// File: rtl/posit_operand_conditioner.sv
// Two-stage posit operand conditioner: negate for SUB, order ADD/SUB by
// magnitude, resolve zero/NaR early. Request side in_*, result side out_*.
module posit_operand_conditioner
    import ppu_pkg::*;
#(
    parameter int N     = 16,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_SIZE-1:0] in_op,
    input  logic [N-1:0]       in_p1,
    input  logic [N-1:0]       in_p2,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OP_SIZE-1:0] out_op,
    output logic [N-1:0]       out_p1,
    output logic [N-1:0]       out_p2,
    output logic               out_swapped,
    output logic               out_special,
    output logic [N-1:0]       out_special_res,
    output logic [TAG_W-1:0]   out_tag
);

    typedef struct packed {
        logic [OP_SIZE-1:0] op;
        logic [TAG_W-1:0]   tag;
        logic [N-1:0]       a;
        logic [N-1:0]       b;
        logic [N-1:0]       mag_a;
        logic [N-1:0]       mag_b;
        logic               za;
        logic               zb;
        logic               na;
        logic               nb;
    } s1_t;

    typedef struct packed {
        logic [OP_SIZE-1:0] op;
        logic [TAG_W-1:0]   tag;
        logic [N-1:0]       p1;
        logic [N-1:0]       p2;
        logic               swapped;
        logic               special;
        logic [N-1:0]       res;
    } s2_t;

    s1_t         s1_d, s1_q;
    s2_t         s2_d, s2_q;
    logic [N-1:0] b_in;
    logic        v1, s2_ready;
    logic        addsub;

    assign b_in = (in_op == SUB) ? N'(c2(pword_t'(in_p2), N)) : in_p2;

    always_comb begin
        s1_d.op    = in_op;
        s1_d.tag   = in_tag;
        s1_d.a     = in_p1;
        s1_d.b     = b_in;
        s1_d.mag_a = N'(abs_posit(pword_t'(in_p1), N));
        s1_d.mag_b = N'(abs_posit(pword_t'(b_in), N));
        s1_d.za    = is_zero(pword_t'(in_p1), N);
        s1_d.zb    = is_zero(pword_t'(b_in), N);
        s1_d.na    = is_nar(pword_t'(in_p1), N);
        s1_d.nb    = is_nar(pword_t'(b_in), N);
    end

    ppu_pipe_reg #(.W($bits(s1_t))) u_s1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (s1_d),
        .out_valid (v1),
        .out_ready (s2_ready),
        .out_data  (s1_q)
    );

    assign addsub = (s1_q.op == ADD) || (s1_q.op == SUB);

    always_comb begin
        s2_d.op      = s1_q.op;
        s2_d.tag     = s1_q.tag;
        s2_d.swapped = addsub && (s1_q.mag_b > s1_q.mag_a);
        s2_d.p1      = s2_d.swapped ? s1_q.b : s1_q.a;
        s2_d.p2      = s2_d.swapped ? s1_q.a : s1_q.b;
        s2_d.special = 1'b1;
        s2_d.res     = '0;
        // priority order matters: NaR dominates, then divide by zero
        if (s1_q.na || s1_q.nb) begin
            s2_d.res = {1'b1, {(N-1){1'b0}}};
        end else if (s1_q.op == DIV && s1_q.zb) begin
            s2_d.res = {1'b1, {(N-1){1'b0}}};
        end else if (s1_q.op == MUL && (s1_q.za || s1_q.zb)) begin
            s2_d.res = '0;
        end else if (s1_q.op == DIV && s1_q.za) begin
            s2_d.res = '0;
        end else if (addsub && s1_q.za) begin
            s2_d.res = s1_q.b;
        end else if (addsub && s1_q.zb) begin
            s2_d.res = s1_q.a;
        end else begin
            s2_d.special = 1'b0;
        end
    end

    ppu_pipe_reg #(.W($bits(s2_t))) u_s2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v1),
        .in_ready  (s2_ready),
        .in_data   (s2_d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (s2_q)
    );

    assign out_op          = s2_q.op;
    assign out_tag         = s2_q.tag;
    assign out_p1          = s2_q.p1;
    assign out_p2          = s2_q.p2;
    assign out_swapped     = s2_q.swapped;
    assign out_special     = s2_q.special;
    assign out_special_res = s2_q.res;

endmodule

// File: tb/tb_posit_operand_conditioner.sv
// Randomized and directed bench for posit_operand_conditioner.
// Reference model uses signed integer arithmetic on 16-bit posits.
module tb_posit_operand_conditioner;

    localparam int N     = 16;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [N-1:0]     in_p1, in_p2;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       out_op;
    logic [N-1:0]     out_p1, out_p2;
    logic             out_swapped;
    logic             out_special;
    logic [N-1:0]     out_special_res;
    logic [TAG_W-1:0] out_tag;

    posit_operand_conditioner #(.N(N), .TAG_W(TAG_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_op           (in_op),
        .in_p1           (in_p1),
        .in_p2           (in_p2),
        .in_tag          (in_tag),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_op          (out_op),
        .out_p1          (out_p1),
        .out_p2          (out_p2),
        .out_swapped     (out_swapped),
        .out_special     (out_special),
        .out_special_res (out_special_res),
        .out_tag         (out_tag)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int n_in     = 0;
    int n_out    = 0;
    bit rand_rdy = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [1:0]       op;
        logic [TAG_W-1:0] tag;
        logic [N-1:0]     p1, p2, res;
        logic             sw, sp;
    } exp_t;

    exp_t q[$];

    function automatic int smag(int x);
        int s;
        s = (x >= 32768) ? x - 65536 : x;
        return (s < 0) ? -s : s;
    endfunction

    function automatic exp_t model(logic [1:0] op, logic [N-1:0] p1,
                                   logic [N-1:0] p2, logic [TAG_W-1:0] tag);
        exp_t e;
        int   a, b;
        bit   addsub;
        a = int'(p1);
        b = (op == 2'd1) ? (65536 - int'(p2)) % 65536 : int'(p2);
        addsub = (op <= 2'd1);
        e.op  = op;
        e.tag = tag;
        e.sw  = addsub && (smag(b) > smag(a));
        e.p1  = e.sw ? 16'(b) : 16'(a);
        e.p2  = e.sw ? 16'(a) : 16'(b);
        e.sp  = 1'b1;
        e.res = 16'h0000;
        if (a == 32768 || b == 32768)            e.res = 16'h8000;
        else if (op == 2'd3 && b == 0)           e.res = 16'h8000;
        else if (op == 2'd2 && (a == 0 || b == 0)) e.res = 16'h0000;
        else if (op == 2'd3 && a == 0)           e.res = 16'h0000;
        else if (addsub && a == 0)               e.res = 16'(b);
        else if (addsub && b == 0)               e.res = 16'(a);
        else                                     e.sp  = 1'b0;
        return e;
    endfunction

    // monitor: scoreboard on transfers, stability while stalled
    logic             stall_prev = 1'b0;
    logic [1:0]       h_op;
    logic [N-1:0]     h_p1, h_p2, h_res;
    logic             h_sw, h_sp;
    logic [TAG_W-1:0] h_tag;
    exp_t             e;

    always @(negedge clk) begin
        if (!rst && in_valid && in_ready) begin
            q.push_back(model(in_op, in_p1, in_p2, in_tag));
            n_in++;
        end
        if (!rst && out_valid && stall_prev) begin
            check("hold", {out_op, out_tag, out_p1, out_p2, out_sw_sp()},
                  {h_op, h_tag, h_p1, h_p2, h_sw, h_sp});
            check("hold_res", out_special_res, h_res);
        end
        if (!rst && out_valid && out_ready) begin
            n_out++;
            if (q.size() == 0) begin
                check("spurious_out", out_tag, 32'hdead);
            end else begin
                e = q.pop_front();
                check("sb_tag", out_tag, e.tag);
                check("sb_op", out_op, e.op);
                check("sb_p1", out_p1, e.p1);
                check("sb_p2", out_p2, e.p2);
                check("sb_sw", out_swapped, e.sw);
                check("sb_sp", out_special, e.sp);
                check("sb_res", out_special_res, e.res);
            end
        end
        stall_prev <= !rst && out_valid && !out_ready;
        h_op  <= out_op;
        h_tag <= out_tag;
        h_p1  <= out_p1;
        h_p2  <= out_p2;
        h_sw  <= out_swapped;
        h_sp  <= out_special;
        h_res <= out_special_res;
    end

    function automatic logic [1:0] out_sw_sp();
        return {out_swapped, out_special};
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // called at posedge+1; returns at posedge+1 after acceptance
    task automatic send(logic [1:0] op, logic [N-1:0] p1,
                        logic [N-1:0] p2, logic [TAG_W-1:0] tag);
        bit acc;
        int n;
        in_valid = 1'b1;
        in_op    = op;
        in_p1    = p1;
        in_p2    = p2;
        in_tag   = tag;
        n = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) check("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic send_chk(string nm, logic [1:0] op,
                            logic [N-1:0] p1, logic [N-1:0] p2,
                            logic [N-1:0] x1, logic [N-1:0] x2,
                            logic xsw, logic xsp, logic [N-1:0] xres);
        send(op, p1, p2, 4'd5);
        @(negedge clk);
        @(negedge clk);
        check({nm, "_vld"}, out_valid, 1);
        check({nm, "_p1"}, out_p1, x1);
        check({nm, "_p2"}, out_p2, x2);
        check({nm, "_sw"}, out_swapped, xsw);
        check({nm, "_sp"}, out_special, xsp);
        check({nm, "_res"}, out_special_res, xres);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N-1:0] pick(logic [N-1:0] other);
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'h8000;
            2:       return other;
            3:       return 16'(-other);
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = '0;
        in_p1     = '0;
        in_p2     = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_vld", out_valid, 0);
        check("rst_data", {out_op, out_tag, out_p1, out_p2}, 0);
        check("rst_flags", {out_swapped, out_special}, 0);
        check("rst_res", out_special_res, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // latency and swap
        send(2'd0, 16'h4000, 16'h5000, 4'd3);
        @(negedge clk);
        check("lat_early", out_valid, 0);
        @(negedge clk);
        check("lat_vld", out_valid, 1);
        check("add_p1", out_p1, 16'h5000);
        check("add_p2", out_p2, 16'h4000);
        check("add_sw", out_swapped, 1);
        check("add_sp", out_special, 0);
        check("add_tag", out_tag, 3);
        @(posedge clk);
        #1;

        send_chk("sub_tie", 2'd1, 16'h4000, 16'h4000,
                 16'h4000, 16'hC000, 1'b0, 1'b0, 16'h0000);
        send_chk("mul_z", 2'd2, 16'h0000, 16'h4000,
                 16'h0000, 16'h4000, 1'b0, 1'b1, 16'h0000);
        send_chk("div_z", 2'd3, 16'h4000, 16'h0000,
                 16'h4000, 16'h0000, 1'b0, 1'b1, 16'h8000);
        send_chk("add_nar", 2'd0, 16'h8000, 16'h4000,
                 16'h8000, 16'h4000, 1'b0, 1'b1, 16'h8000);
        send_chk("add_za", 2'd0, 16'h0000, 16'h3000,
                 16'h3000, 16'h0000, 1'b1, 1'b1, 16'h3000);

        // backpressure
        out_ready = 1'b0;
        send(2'd0, 16'h1111, 16'h2222, 4'd1);
        send(2'd2, 16'h3333, 16'h4444, 4'd2);
        in_valid = 1'b1;
        in_op    = 2'd3;
        in_p1    = 16'h5555;
        in_p2    = 16'h6666;
        in_tag   = 4'd3;
        @(negedge clk);
        check("bp_in_ready", in_ready, 0);
        check("bp_tag1", out_tag, 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_hold_tag", out_tag, 1);
        check("bp_in_ready2", in_ready, 0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("bp_tag2", {out_valid, out_tag}, {1'b1, 4'd2});
        @(negedge clk);
        check("bp_tag3", {out_valid, out_tag}, {1'b1, 4'd3});
        @(posedge clk);
        #1;

        // streaming
        rand_rdy = 1;
        for (int i = 0; i < 100; i++) begin
            logic [N-1:0] a;
            a = 16'($urandom);
            if ($urandom_range(0, 7) == 0) a = 16'h0000;
            if ($urandom_range(0, 9) == 0) a = 16'h8000;
            send(2'($urandom), a, pick(a), 4'($urandom));
        end
        rand_rdy = 0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
        check("drain", q.size(), 0);
        check("count", n_out, n_in);
        @(posedge clk);
        #1;

        // reset with two requests in flight
        out_ready = 1'b0;
        send(2'd0, 16'h1234, 16'h0456, 4'd9);
        send(2'd1, 16'h2345, 16'h0567, 4'd10);
        #1 rst = 1'b1;
        q.delete();
        #1;
        check("rst_mid_vld", out_valid, 0);
        @(negedge clk);
        check("rst_mid_vld2", out_valid, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("rst_mid_in_ready", in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_no_stale", out_valid, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/posit_operand_conditioner.md
# posit_operand_conditioner

Pipelined, handshaked operand conditioning stage at the front of the posit processing unit (PPU). For each operation it:
- negates the second operand for subtraction;
- orders ADD/SUB operands by magnitude;
- detects zero/NaR special cases and produces the special result early.

It sits between the PPU request interface and the decode/core stages. Downstream datapaths see pre-ordered operands plus a bypass flag, with full valid/ready backpressure and a passthrough tag.

## Interface
Parameters:
- N, 16: posit width in bits (≥ 4).
- TAG_W, 4: width of the opaque request tag carried alongside the operands.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  stage can accept a request this cycle.
- in_op  in  OP_SIZE  operation code from ppu_pkg (ADD, SUB, MUL, DIV).
- in_p1  in  N  first operand (posit bits).
- in_p2  in  N  second operand (posit bits).
- in_tag  in  TAG_W  request tag.
- out_valid  out  1  conditioned result present.
- out_ready  in  1  downstream accepts this cycle.
- out_op  out  OP_SIZE  operation, unchanged.
- out_p1  out  N  conditioned first operand.
- out_p2  out  N  conditioned second operand.
- out_swapped  out  1  operands were exchanged.
- out_special  out  1  result is fully determined; core bypass.
- out_special_res  out  N  the determined result, valid when out_special = 1.
- out_tag  out  TAG_W  tag of the request.

## Operation
- Transfer on each side occurs when valid && ready.
- Stage S1, registered on input transfer. Stores op and tag, plus:
  - a = in_p1;
  - b = (op == SUB) ? two's complement of in_p2 : in_p2;
  - |a| and |b|, each computed as the MSB-conditional two's complement, compared unsigned;
  - zero flags (all bits 0) and NaR flags (1 followed by N−1 zeros) for a and b.
- Stage S2, registered on S1→S2 advance:
  - Swap: if op ∈ {ADD, SUB} and |b| > |a|, then out_p1 = b, out_p2 = a and out_swapped = 1. Otherwise out_p1 = a and out_p2 = b.
  - Ties do not swap.
  - The magnitude of NaR is 2^(N−1), i.e. the largest value.
- Special-case rules, evaluated in S1 on a/b; priority top-down:
  - Any NaR operand → special, result NaR.
  - DIV with b zero → special, NaR.
  - MUL with any zero operand → special, 0.
  - DIV with a zero → special, 0.
  - ADD/SUB with a zero → special, result b (already negated for SUB).
  - ADD/SUB with b zero → special, result a.
  - Otherwise out_special = 0 and out_special_res = 0.
- Swap still applies when out_special = 1; out_p1/out_p2 remain meaningful.
- Each stage holds a valid bit.
  - Stage k accepts when !valid_k || ready_(k+1), where ready_3 = out_ready.
  - in_ready = !v1 || (!v2 || out_ready).
- Order is strictly preserved. No request is dropped or duplicated.

## Timing
- Latency: 2 cycles from input transfer to out_valid when unstalled. Throughput is 1 per cycle.
- Reset:
  - v1, v2, out_valid, out_swapped and out_special are 0.
  - All data outputs (out_p1, out_p2, out_special_res, out_op, out_tag) are 0.
  - in_ready is 1 from the first cycle after reset deassertion.
- Reset mid-operation: all in-flight requests are discarded immediately (asynchronous). No output transfer occurs in the reset cycle.
- While out_valid && !out_ready: every out_* signal is held stable. S1 may still fill if empty.
- Full pipeline stalled (v1 = v2 = 1, out_ready = 0): in_ready = 0. in_ready depends combinationally on out_ready; no other combinational in→out paths exist.
- Simultaneous output and input transfer on a full pipeline: both stages advance in the same edge with no bubble.

## Structure
- ppu_pkg (shared):
  - OP_SIZE = 2;
  - op constants ADD = 0, SUB = 1, MUL = 2, DIV = 3;
  - functions c2, abs_posit, is_zero and is_nar, all parameterised by N.
- No sub-module is mandated.
- One natural sub-module is ppu_pipe_reg: a valid/ready register slice with a generic payload width, instantiated twice.

## Test plan
N = 16, TAG_W = 4 throughout.
- Reset then ADD p1 = 0x4000, p2 = 0x5000, tag 3, with out_ready = 1 → two cycles later: out_p1 = 0x5000, out_p2 = 0x4000, swapped = 1, special = 0, tag 3.
- SUB p1 = 0x4000, p2 = 0x4000 → out_p1 = 0x4000, out_p2 = 0xC000, swapped = 0 (tie).
- MUL p1 = 0x0000, p2 = 0x4000 → special = 1, res = 0x0000. DIV p1 = 0x4000, p2 = 0x0000 → special = 1, res = 0x8000. ADD p1 = 0x8000, p2 = 0x4000 → special = 1, res = 0x8000.
- Backpressure: out_ready = 0 while offering tags 1, 2, 3 back-to-back.
  - Tags 1 and 2 are accepted; in_ready drops for tag 3.
  - Outputs hold tag 1 stable.
  - Raise out_ready → tags 1, 2, 3 emerge in order on consecutive cycles.
- Streaming: 100 random back-to-back requests with random out_ready → results match the reference model, with order and count preserved.
- Assert rst while two requests are in flight → out_valid = 0 immediately. After release, no stale tags appear and in_ready = 1.
